// File: rtl/reset_seq_sync.sv
// Reset sequencer for one clock domain: synchronises async reset release, holds reset
// for HOLD_CYCLES, then releases NUM_CH active-low resets in staggered order.
module reset_seq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4,
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst_req,
    input  logic [DATA_W-1:0] i_a,
    output logic [DATA_W-1:0] o_a,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              rst_done
);
    localparam int MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0]  HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STEP_TC = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [NUM_CH-1:0] CH_ONE  = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STAGGER = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst_n_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      rst_q, rst_d;
    logic                   done_q, done_d;
    logic [DATA_W-1:0]      oa_q, oa_d;

    assign sync_rst_n_s = sync_q[SYNC_STAGES-1];

    // Release synchroniser: shifts in ones after rst_n deasserts; untouched by sw_rst_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            cnt_q   <= {CNT_W{1'b0}};
            rst_q   <= {NUM_CH{1'b0}};
            done_q  <= 1'b0;
            oa_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            oa_q    <= oa_d;
        end
    end

    // Next-state logic; a software request overrides every state and restarts the hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (sw_rst_req) begin
            state_d = S_HOLD;
            cnt_d   = {CNT_W{1'b0}};
            rst_d   = {NUM_CH{1'b0}};
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (!sync_rst_n_s) begin
                        cnt_d = {CNT_W{1'b0}};
                    end else if (cnt_q == HOLD_TC) begin
                        cnt_d = {CNT_W{1'b0}};
                        rst_d = CH_ONE;
                        if (NUM_CH == 1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_STAGGER;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STAGGER: begin
                    if (cnt_q == STEP_TC) begin
                        cnt_d = {CNT_W{1'b0}};
                        rst_d = (rst_q << 1'b1) | CH_ONE;
                        if (rst_d[NUM_CH-1]) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_STAGGER;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    rst_d  = {NUM_CH{1'b1}};
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                    rst_d   = {NUM_CH{1'b0}};
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Data register is held at zero until channel 0 has been released.
    always_comb begin
        if (rst_q[0]) begin
            oa_d = i_a;
        end else begin
            oa_d = {DATA_W{1'b0}};
        end
    end

    assign o_a       = oa_q;
    assign rst_out_n = rst_q;
    assign rst_done  = done_q;
endmodule

// File: tb/tb_reset_seq_sync.sv
// Bench for reset_seq_sync: default and minimal parameter sets against a release-time model.
module tb_reset_seq_sync;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst_req;
    logic [7:0] i_a;
    logic [7:0] o_a0, o_a1;
    logic [2:0] r0;
    logic [0:0] r1;
    logic       d0, d1;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    reset_seq_sync dut0 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .i_a(i_a),
        .o_a(o_a0), .rst_out_n(r0), .rst_done(d0)
    );

    reset_seq_sync #(
        .SYNC_STAGES(3), .HOLD_CYCLES(1), .STEP_CYCLES(1), .NUM_CH(1), .DATA_W(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .i_a(i_a),
        .o_a(o_a1), .rst_out_n(r1), .rst_done(d1)
    );

    initial forever #5 clk = ~clk;

    // Model: n = edges since release, k = last edge a software request was sampled.
    // Channels released after edge e: anchor = max(SYNC, k); channel i up once e >= anchor+H+i*S.
    int n, k;
    logic [7:0] exp_oa0, exp_oa1;

    function automatic int rel(int e, int sync, int kk, int h, int s, int nc);
        int a, c;
        a = (kk > sync) ? kk : sync;
        if (e < a + h) return 0;
        c = 1 + (e - a - h) / s;
        return (c > nc) ? nc : c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0; k <= 0; exp_oa0 <= 8'h00; exp_oa1 <= 8'h00;
        end else begin
            n <= n + 1;
            if (sw_rst_req) k <= n + 1;
            exp_oa0 <= (rel(n, 2, k, 16, 4, 3) >= 1) ? i_a : 8'h00;
            exp_oa1 <= (rel(n, 3, k, 1, 1, 1) >= 1) ? i_a : 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic check_all(input string tag);
        int c0, c1;
        c0 = rel(n, 2, k, 16, 4, 3);
        c1 = rel(n, 3, k, 1, 1, 1);
        chk({tag, " rst0"}, 32'(r0), 32'((1 << c0) - 1));
        chk({tag, " done0"}, 32'(d0), 32'(c0 == 3));
        chk({tag, " oa0"}, 32'(o_a0), 32'(exp_oa0));
        chk({tag, " rst1"}, 32'(r1), 32'((1 << c1) - 1));
        chk({tag, " done1"}, 32'(d1), 32'(c1 == 1));
        chk({tag, " oa1"}, 32'(o_a1), 32'(exp_oa1));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) check_all("cyc");
    end

    task automatic step_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("step_to", 32'(n), 32'(target));
    endtask

    task automatic async_pulse();
        #2 rst_n = 1'b0;
        #1 check_all("async");
        chk("async rst0 lit", 32'(r0), 32'h0);
        chk("async oa0 lit", 32'(o_a0), 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int kp, last;
        rst_n = 1'b0; sw_rst_req = 1'b0; i_a = 8'hA5;
        repeat (3) @(negedge clk);
        chk("por rst0", 32'(r0), 32'h0);
        chk("por done0", 32'(d0), 32'h0);
        chk("por oa0", 32'(o_a0), 32'h0);
        cmp_en = 1'b1;
        rst_n = 1'b1;

        step_to(3);  chk("E3 rst1", 32'(r1), 32'h0);
        step_to(4);  chk("E4 rst1", 32'(r1), 32'h1); chk("E4 done1", 32'(d1), 32'h1);
        step_to(17); chk("E17 rst0", 32'(r0), 32'h0);
        step_to(18); chk("E18 rst0", 32'(r0), 32'h1); chk("E18 oa0", 32'(o_a0), 32'h00);
        step_to(19); chk("E19 oa0", 32'(o_a0), 32'hA5);
        step_to(21); chk("E21 rst0", 32'(r0), 32'h1);
        step_to(22); chk("E22 rst0", 32'(r0), 32'h3);
        step_to(25); chk("E25 done0", 32'(d0), 32'h0);
        step_to(26); chk("E26 rst0", 32'(r0), 32'h7); chk("E26 done0", 32'(d0), 32'h1);
        step_to(29); i_a = 8'h3C;
        step_to(30); chk("E30 oa0", 32'(o_a0), 32'h3C);

        // One-cycle software request in DONE.
        step_to(35);
        sw_rst_req = 1'b1; @(negedge clk); sw_rst_req = 1'b0; kp = n;
        chk("sw k rst0", 32'(r0), 32'h0); chk("sw k done0", 32'(d0), 32'h0);
        step_to(kp + 15); chk("sw k+15 rst0", 32'(r0), 32'h0);
        step_to(kp + 16); chk("sw k+16 rst0", 32'(r0), 32'h1);
        step_to(kp + 23); chk("sw k+23 rst0", 32'(r0), 32'h3);
        step_to(kp + 24); chk("sw k+24 rst0", 32'(r0), 32'h7); chk("sw k+24 done0", 32'(d0), 32'h1);

        // Request held 10 cycles from mid-stagger.
        sw_rst_req = 1'b1; @(negedge clk); sw_rst_req = 1'b0; kp = n;
        step_to(kp + 18); chk("mid rst0", 32'(r0), 32'h1);
        sw_rst_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("held rst0", 32'(r0), 32'h0);
        end
        sw_rst_req = 1'b0; last = n;
        step_to(last + 15); chk("held +15 rst0", 32'(r0), 32'h0);
        step_to(last + 16); chk("held +16 rst0", 32'(r0), 32'h1);
        step_to(last + 24); chk("held +24 done0", 32'(d0), 32'h1);

        // Short async pulse in DONE, then full restart.
        async_pulse();
        step_to(17); chk("re E17 rst0", 32'(r0), 32'h0);
        step_to(18); chk("re E18 rst0", 32'(r0), 32'h1);
        step_to(22); chk("re E22 rst0", 32'(r0), 32'h3);
        step_to(26); chk("re E26 rst0", 32'(r0), 32'h7); chk("re E26 done0", 32'(d0), 32'h1);

        // Randomised traffic: sparse then dense software requests, rare async pulses.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            i_a = 8'($urandom);
            sw_rst_req = ($urandom_range(0, (i < 250) ? 39 : 7) == 0);
            if ($urandom_range(0, 99) == 0) async_pulse();
        end
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
